uart_hex_arbiter: RTL and testbench

UART_HEX_ARBITER -- requirements
Module: uart_hex_arbiter

---
 rtl/uart_hex_arbiter.sv | 113 +++++++++++
 tb/tb_uart_hex_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_hex_arbiter: round-robin arbiter feeding one shared hex-dump           |
// | transmitter from NPORTS single-word holding registers.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_hex_arbiter #(
  parameter int NPORTS = 4,
  parameter int W      = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NPORTS-1:0]           i_stb,
  input  logic [NPORTS*W-1:0]         i_data,
  output logic [NPORTS-1:0]           o_busy,
  output logic                        o_tx_stb,
  output logic [W-1:0]                o_tx_data,
  input  logic                        i_tx_busy,
  output logic [$clog2(NPORTS)-1:0]   o_grant_id
);

  localparam int IDW = $clog2(NPORTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                   r_state;
  logic [NPORTS-1:0]        r_pending;
  logic [NPORTS-1:0][W-1:0] r_hold;
  logic [IDW-1:0]           r_rr_ptr;

  logic                     w_sel_valid;
  logic [IDW-1:0]           w_sel_idx;
  logic [IDW-1:0]           w_rr_next;
  logic                     w_grant;

  // Scan from the farthest offset down so the nearest pending port at or
  // after the pointer is the last (winning) assignment.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (r_pending[(int'(r_rr_ptr) + i) % NPORTS]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDW'((int'(r_rr_ptr) + i) % NPORTS);
      end
    end
  end

  assign w_rr_next = (w_sel_idx == IDW'(NPORTS - 1)) ? '0 : w_sel_idx + IDW'(1);
  assign w_grant   = (r_state == IDLE) && w_sel_valid;
  assign o_busy    = r_pending;

  // Capture needs !pending and grant needs pending, so the two never collide;
  // this also drops a strobe that arrives on the grant edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
      r_hold    <= '0;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (i_stb[k] && !r_pending[k]) begin
          r_pending[k] <= 1'b1;
          r_hold[k]    <= i_data[k*W +: W];
        end else if (w_grant && (w_sel_idx == IDW'(k))) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      o_tx_stb   <= 1'b0;
      o_tx_data  <= '0;
      o_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            o_tx_data  <= r_hold[w_sel_idx];
            o_grant_id <= w_sel_idx;
            o_tx_stb   <= 1'b1;
            r_rr_ptr   <= w_rr_next;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i_tx_busy) begin
            o_tx_stb <= 1'b0;
            r_state  <= SETTLE;
          end
        end
        // Transmitter busy lags acceptance by a cycle, so it is not trusted here.
        SETTLE: r_state <= DRAIN;
        DRAIN: begin
          if (!i_tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_hex_arbiter: directed scenarios plus randomized traffic against a  |
// | transaction-level model of the arbiter. Revision: 1.0                      |
// +----------------------------------------------------------------------------+
module tb_uart_hex_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    stb;
  logic [NP*DW-1:0] data;
  logic [NP-1:0]    busy;
  logic             tx_stb;
  logic [DW-1:0]    tx_data;
  logic             tx_busy;
  logic [1:0]       grant_id;

  always #5 clk = ~clk;

  uart_hex_arbiter #(.NPORTS(NP), .W(DW)) dut (
    .i_clk(clk), .i_reset(reset), .i_stb(stb), .i_data(data), .o_busy(busy),
    .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy), .o_grant_id(grant_id)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: one slot per port, a round-robin pointer, and the progress of
  // the single outstanding transmission (0 free, 1 offered, 2 settle, 3 drain).
  logic [NP-1:0] m_pend;
  logic [DW-1:0] m_word [NP];
  int            m_rr;
  int            m_phase;
  logic          m_stb;
  logic [DW-1:0] m_data;
  logic [1:0]    m_gid;

  bit            tx_auto;
  int            tx_cnt;
  logic [DW-1:0] acc_data_q [$];
  int            acc_gid_q  [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [NP-1:0] old;
    logic          acc;
    int            k;
    if (tx_stb && !tx_busy) begin
      acc_data_q.push_back(tx_data);
      acc_gid_q.push_back(int'(grant_id));
    end
    acc = m_stb && !tx_busy;
    @(posedge clk);
    if (reset) begin
      m_pend = '0; m_rr = 0; m_phase = 0; m_stb = 1'b0; m_data = '0; m_gid = '0;
    end else begin
      old = m_pend;
      case (m_phase)
        0: if (old != '0) begin
          k = m_rr;
          while (!old[k]) k = (k + 1) % NP;
          m_data = m_word[k]; m_gid = 2'(k); m_pend[k] = 1'b0;
          m_stb = 1'b1; m_rr = (k + 1) % NP; m_phase = 1;
        end
        1: if (acc) begin m_stb = 1'b0; m_phase = 2; end
        2: m_phase = 3;
        default: if (!tx_busy) m_phase = 0;
      endcase
      for (int p = 0; p < NP; p++)
        if (stb[p] && !old[p]) begin
          m_pend[p] = 1'b1;
          m_word[p] = data[p*DW +: DW];
        end
    end
    #1;
    check("busy", busy, m_pend);
    check("tx_stb", tx_stb, m_stb);
    check("tx_data", tx_data, m_data);
    check("grant_id", grant_id, m_gid);
    if (tx_auto) begin
      if (acc && !reset) tx_cnt = $urandom_range(1, 4);
      else if (tx_cnt > 0) tx_cnt--;
      tx_busy = (tx_cnt > 0) || ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stb = '0; tx_auto = 1'b0; tx_busy = 1'b0; tx_cnt = 0;
    step(); step();
    reset = 1'b0;
    acc_data_q.delete(); acc_gid_q.delete();
  endtask

  logic [DW-1:0] exp29_d [3];
  int            exp29_g [3];
  int            n;

  initial begin
    reset = 1'b1; stb = '0; data = '0; tx_busy = 1'b0; tx_auto = 1'b0; tx_cnt = 0;
    m_pend = '0; m_rr = 0; m_phase = 0; m_stb = 1'b0; m_data = '0; m_gid = '0;

    // Reset state and single request straight after reset deasserts
    do_reset();
    check("rst_busy", busy, 0); check("rst_stb", tx_stb, 0);
    check("rst_data", tx_data, 0); check("rst_gid", grant_id, 0);
    data[2*DW +: DW] = 32'hDEADBEEF; stb = 4'b0100;
    step();
    check("single_busy_set", busy, 4'b0100); check("single_stb_early", tx_stb, 0);
    stb = '0;
    step();
    check("single_stb", tx_stb, 1); check("single_data", tx_data, 32'hDEADBEEF);
    check("single_gid", grant_id, 2); check("single_busy_clr", busy, 0);
    step();
    check("single_accept", tx_stb, 0);
    tx_busy = 1'b1; step(); step(); tx_busy = 1'b0; step(); step();

    // Simultaneous requests from ports 0,1,3
    do_reset();
    data[0 +: DW] = 32'h11; data[DW +: DW] = 32'h22; data[3*DW +: DW] = 32'h33;
    stb = 4'b1011;
    step();
    stb = '0; tx_auto = 1'b1;
    repeat (100) step();
    tx_auto = 1'b0; tx_busy = 1'b0;
    exp29_d[0] = 32'h11; exp29_d[1] = 32'h22; exp29_d[2] = 32'h33;
    exp29_g[0] = 0; exp29_g[1] = 1; exp29_g[2] = 3;
    check("simul_count", acc_data_q.size(), 3);
    n = (acc_data_q.size() < 3) ? acc_data_q.size() : 3;
    for (int i = 0; i < n; i++) begin
      check("simul_data", acc_data_q[i], exp29_d[i]);
      check("simul_gid", acc_gid_q[i], exp29_g[i]);
    end

    // Backpressure while offered
    do_reset();
    data[DW +: DW] = 32'hCAFE0001; stb = 4'b0010; tx_busy = 1'b1;
    step();
    stb = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stb_hold", tx_stb, 1); check("bp_data_hold", tx_data, 32'hCAFE0001);
    end
    tx_busy = 1'b0;
    step();
    check("bp_stb_drop", tx_stb, 0);
    tx_busy = 1'b1; step(); tx_busy = 1'b0; step(); step();

    // Fairness under continuous requests
    do_reset();
    tx_auto = 1'b1;
    for (int cyc = 0; cyc < 800 && acc_gid_q.size() < 12; cyc++) begin
      stb = '1;
      for (int p = 0; p < NP; p++) data[p*DW +: DW] = $urandom;
      step();
    end
    stb = '0; tx_auto = 1'b0; tx_busy = 1'b0;
    check("fair_count", acc_gid_q.size() >= 12, 1);
    n = (acc_gid_q.size() < 12) ? acc_gid_q.size() : 12;
    for (int i = 0; i < n; i++) check("fair_gid", acc_gid_q[i], i % 4);

    // Strobes while the holding register is full are dropped
    do_reset();
    tx_busy = 1'b1;
    data[0 +: DW] = 32'h5; stb = 4'b0001;
    step();
    stb = '0; step();
    data[DW +: DW] = 32'hA; stb = 4'b0010; step();
    check("drop_busy1", busy[1], 1);
    stb = '0; step();
    data[DW +: DW] = 32'hB; stb = 4'b0010; step();
    stb = '0; step();
    data[DW +: DW] = 32'hC; stb = 4'b0010; step();
    stb = '0; tx_auto = 1'b1;
    repeat (80) step();
    tx_auto = 1'b0; tx_busy = 1'b0;
    check("drop_count", acc_data_q.size(), 2);
    if (acc_data_q.size() >= 2) begin
      check("drop_first", acc_data_q[0], 32'h5);
      check("drop_second", acc_data_q[1], 32'hA);
    end

    // Reset during drain with ports 0 and 2 pending
    do_reset();
    data[DW +: DW] = 32'h77; stb = 4'b0010;
    step();
    stb = '0; step(); step();
    tx_busy = 1'b1;
    data[0 +: DW] = 32'h100; data[2*DW +: DW] = 32'h300; stb = 4'b0101;
    step();
    stb = '0; step();
    check("rmid_pend", busy, 4'b0101);
    reset = 1'b1; step(); reset = 1'b0;
    check("rmid_busy", busy, 0); check("rmid_stb", tx_stb, 0);
    check("rmid_data", tx_data, 0); check("rmid_gid", grant_id, 0);
    tx_busy = 1'b0; acc_data_q.delete(); acc_gid_q.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      check("rmid_quiet", tx_stb, 0);
    end
    data[0 +: DW] = 32'h42; stb = 4'b0001; step(); stb = '0; step();
    check("rmid_new_stb", tx_stb, 1); check("rmid_new_data", tx_data, 32'h42);

    // Randomized traffic with occasional resets
    do_reset();
    tx_auto = 1'b1;
    repeat (2000) begin
      for (int p = 0; p < NP; p++) begin
        stb[p] = ($urandom_range(0, 9) < 3);
        data[p*DW +: DW] = $urandom;
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0; stb = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
